// File: rtl/tx_source_arbiter.sv
// Shares one UART transmitter between a one-byte general holding register and bursts from the ADC FIFO.
// Define TX_ARB_HEADER_EN to begin every ADC burst with HEADER_BYTE; header sending is absent by default.
module tx_source_arbiter #(
    parameter int         ADC_BURST   = 16,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] generalData,
    input  logic       generalDataWrite,
    input  logic       adcStreamReady,
    input  logic [7:0] adcData,
    input  logic       adcDataValid,
    input  logic       txBusy,
    output logic       adcDataStrobe,
    output logic [7:0] txData,
    output logic       txStart,
    output logic       generalBusy,
    output logic       generalOverflow,
    output logic       adcTimeout
);

    localparam logic [7:0] BURST_LIMIT = 8'(ADC_BURST);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GEN_SEND  = 3'd1,
        ADC_REQ   = 3'd2,
        ADC_WAITV = 3'd3,
        ADC_SEND  = 3'd4,
        TX_WAIT   = 3'd5
`ifdef TX_ARB_HEADER_EN
        ,
        HDR_SEND  = 3'd6
`endif
    } state_e;

    typedef enum logic [1:0] {SRC_GEN, SRC_ADC, SRC_HDR} src_e;

    state_e     state_q, state_d;
    src_e       src_q, src_d;
    logic [1:0] tmr_q, tmr_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       gen_full_q, gen_full_d;
    logic [7:0] gen_data_q, gen_data_d;
    logic       gen_ovf_q, gen_ovf_d;

    logic gen_launch, hdr_launch, adc_launch;
    logic adc_latch, adc_expire, tx_done, burst_end;

    assign gen_launch = (state_q == GEN_SEND) && !txBusy;
    assign adc_launch = (state_q == ADC_SEND) && !txBusy;
    assign adc_latch  = (state_q == ADC_WAITV) && adcDataValid;
    // Timer counts 0..3 over the four cycles following the strobe.
    assign adc_expire = (state_q == ADC_WAITV) && !adcDataValid && (tmr_q == 2'd3);
    assign tx_done    = (state_q == TX_WAIT) && tmr_q[1] && !txBusy;
    assign burst_end  = (burst_cnt_q == BURST_LIMIT) || !adcStreamReady;

`ifdef TX_ARB_HEADER_EN
    assign hdr_launch = (state_q == HDR_SEND) && !txBusy;
`else
    assign hdr_launch = 1'b0;
`endif

    // NOTE: asynchronous reset in the sensitivity list; flops use non-blocking assignments only.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gen_full_q) begin
                    state_d = GEN_SEND;
                end else if (adcStreamReady) begin
`ifdef TX_ARB_HEADER_EN
                    state_d = HDR_SEND;
`else
                    state_d = ADC_REQ;
`endif
                end
            end
            GEN_SEND:  if (gen_launch) state_d = TX_WAIT;
`ifdef TX_ARB_HEADER_EN
            HDR_SEND:  if (hdr_launch) state_d = TX_WAIT;
`endif
            ADC_REQ:   state_d = ADC_WAITV;
            ADC_WAITV: begin
                if (adc_latch) begin
                    state_d = ADC_SEND;
                end else if (adc_expire) begin
                    state_d = IDLE;
                end
            end
            ADC_SEND:  if (adc_launch) state_d = TX_WAIT;
            TX_WAIT: begin
                if (tx_done) begin
                    case (src_q)
                        SRC_ADC: state_d = burst_end ? IDLE : ADC_REQ;
                        SRC_HDR: state_d = ADC_REQ;
                        default: state_d = IDLE;
                    endcase
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start_d = gen_launch | hdr_launch | adc_launch;

        tx_data_d = tx_data_q;
        if (gen_launch) begin
            tx_data_d = gen_data_q;
        end else if (hdr_launch) begin
            tx_data_d = HEADER_BYTE;
        end else if (adc_latch) begin
            tx_data_d = adcData;
        end

        src_d = src_q;
        if (gen_launch) src_d = SRC_GEN;
        if (hdr_launch) src_d = SRC_HDR;
        if (adc_launch) src_d = SRC_ADC;

        burst_cnt_d = burst_cnt_q;
        if (adc_launch) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end else if (adc_expire || (tx_done && (src_q == SRC_ADC) && burst_end)) begin
            burst_cnt_d = 8'd0;
        end

        // A write in the launch cycle refills the register instead of overflowing.
        gen_full_d = gen_full_q && !gen_launch;
        gen_data_d = gen_data_q;
        gen_ovf_d  = gen_ovf_q;
        if (generalDataWrite) begin
            if (!gen_full_q || gen_launch) begin
                gen_full_d = 1'b1;
                gen_data_d = generalData;
            end else begin
                gen_ovf_d = 1'b1;
            end
        end

        if (state_d != state_q) begin
            tmr_d = 2'd0;
        end else if (tmr_q != 2'd3) begin
            tmr_d = tmr_q + 2'd1;
        end else begin
            tmr_d = tmr_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            src_q       <= SRC_GEN;
            tmr_q       <= 2'd0;
            burst_cnt_q <= 8'd0;
            tx_data_q   <= 8'd0;
            tx_start_q  <= 1'b0;
            gen_full_q  <= 1'b0;
            gen_data_q  <= 8'd0;
            gen_ovf_q   <= 1'b0;
        end else begin
            src_q       <= src_d;
            tmr_q       <= tmr_d;
            burst_cnt_q <= burst_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            gen_full_q  <= gen_full_d;
            gen_data_q  <= gen_data_d;
            gen_ovf_q   <= gen_ovf_d;
        end
    end

    always_comb begin
        adcDataStrobe = (state_q == ADC_REQ);
        adcTimeout    = adc_expire;
    end

    assign txData          = tx_data_q;
    assign txStart         = tx_start_q;
    assign generalBusy     = gen_full_q;
    assign generalOverflow = gen_ovf_q;

endmodule
